// File: rtl/op_exec_pkg.sv
// op_exec_pkg: opcode and FSM state types shared by op_exec and its ALU.
package op_exec_pkg;

    localparam int OP_COUNT = 9;
    localparam int OP_W     = 4;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SHR,
        OP_GT,
        OP_EQ,
        OP_AND,
        OP_ROR,
        OP_LOR,
        OP_CAT,
        OP_SEL
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SHIFT,
        RESP
    } state_e;

endpackage

// File: rtl/op_exec_alu.sv
// op_exec_alu: combinational result select for one captured opcode.
// OP_EXEC_SERIAL_SHIFT_EN removes the barrel shifter (SHR is serialised by the caller).
module op_exec_alu
    import op_exec_pkg::*;
#(
    parameter int W = OP_W
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [W-1:0] res,
    output logic         illegal
);

    logic gt_ab;
    logic gt_ad;

    assign gt_ab   = a > b;
    assign gt_ad   = a > d;
    assign illegal = op >= 4'(OP_COUNT);

    always_comb begin
        res = '0;
        case (op)
            OP_ADD: res = b + c;
`ifdef OP_EXEC_SERIAL_SHIFT_EN
            OP_SHR: res = '0;
`else
            OP_SHR: res = b >> c;
`endif
            OP_GT:  res = W'(gt_ab);
            OP_EQ:  res = W'(a == d);
            OP_AND: res = b & c;
            OP_ROR: res = W'(|b);
            OP_LOR: res = W'(gt_ab || gt_ad);
            OP_CAT: res = W'({c[1:0], d[W-1:W-2]});
            OP_SEL: res = gt_ab ? a : b;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/op_exec.sv
// op_exec: valid/ready request/response wrapper executing one opcode per transaction.
// OP_EXEC_SERIAL_SHIFT_EN: SHR shifts one bit per cycle in SHIFT instead of a barrel shifter.
module op_exec
    import op_exec_pkg::*;
#(
    parameter int W = OP_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic [W-1:0] req_c,
    input  logic [W-1:0] req_d,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic [3:0]   rsp_op,
    output logic         rsp_err
);

    state_e       state_q, state_d;
    logic [3:0]   op_q, op_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [W-1:0] data_q, data_d;
    logic         err_q, err_d;
    logic [W-1:0] alu_res;
    logic         alu_ill;

`ifdef OP_EXEC_SERIAL_SHIFT_EN
    localparam int         CW  = $clog2(W + 1);
    localparam logic [W:0] W_V = (W + 1)'(W);
    logic [W-1:0]  sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_init;
    // Shifting by W or more empties the register, so clamp the cycle count at W.
    assign cnt_init = ({1'b0, c_q} > W_V) ? CW'(W) : CW'(c_q);
`else
`endif

    op_exec_alu #(.W(W)) u_alu (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .c       (c_q),
        .d       (d_q),
        .res     (alu_res),
        .illegal (alu_ill)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef OP_EXEC_SERIAL_SHIFT_EN
        sh_d    = sh_q;
        cnt_d   = cnt_q;
`else
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    c_d     = req_c;
                    d_d     = req_d;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                data_d  = alu_res;
                err_d   = alu_ill;
                state_d = RESP;
`ifdef OP_EXEC_SERIAL_SHIFT_EN
                if (op_q == OP_SHR) begin
                    sh_d   = b_q;
                    cnt_d  = cnt_init;
                    data_d = b_q;
                    if (cnt_init != '0) state_d = SHIFT;
                end
`else
`endif
            end
            SHIFT: begin
`ifdef OP_EXEC_SERIAL_SHIFT_EN
                sh_d  = sh_q >> 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    data_d  = sh_q >> 1;
                    state_d = RESP;
                end
`else
                state_d = RESP;
`endif
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef OP_EXEC_SERIAL_SHIFT_EN
            sh_q    <= '0;
            cnt_q   <= '0;
`else
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef OP_EXEC_SERIAL_SHIFT_EN
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
`else
`endif
        end
    end

    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_data  = data_q;
    assign rsp_op    = op_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_op_exec.sv
// tb_op_exec: scoreboard bench for op_exec (result, echo, error flag, latency, handshakes).
module tb_op_exec;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_op = '0;
    logic [3:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_data;
    logic [3:0] rsp_op;
    logic       rsp_err;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] data;
        logic [3:0] op;
        logic       err;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    op_exec #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_d     (req_d),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_op    (rsp_op),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] model(input logic [3:0] op, input logic [3:0] a, b, c, d);
        case (op)
            4'd0: return b + c;
            4'd1: return b >> c;
            4'd2: return {3'b000, a > b};
            4'd3: return {3'b000, a == d};
            4'd4: return b & c;
            4'd5: return {3'b000, b != 4'd0};
            4'd6: return {3'b000, (a > b) || (a > d)};
            4'd7: return {c[1:0], d[3:2]};
            4'd8: return (a > b) ? a : b;
            default: return 4'd0;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] op, input logic [3:0] c);
`ifdef OP_EXEC_SERIAL_SHIFT_EN
        if (op == 4'd1) return 2 + ((c > 4'd4) ? 4 : int'(c));
`endif
        return 2;
    endfunction

    // Drives one request from a negedge; returns at the negedge after the handshake (cycle k+1).
    task automatic send(input logic [3:0] op, input logic [3:0] a, b, c, d, input logic [3:0] exp_data);
        exp_t e;
        int n = 0;
        req_op = op; req_a = a; req_b = b; req_c = c; req_d = d;
        req_valid = 1'b1;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_timeout", 0, 1);
        end else begin
            e.data = exp_data;
            e.op   = op;
            e.err  = op > 4'd8;
            e.cyc  = cyc + lat_of(op, c);
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Waits for the response, compares it against the scoreboard, optionally stalls it.
    task automatic recv(input int hold);
        exp_t e;
        logic [3:0] d0, o0;
        int n = 0;
        rsp_ready = (hold == 0);
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid || sb.size() == 0) begin
            chk("rsp_timeout", 0, 1);
            rsp_ready = 1'b1;
            return;
        end
        e = sb.pop_front();
        chk("latency", cyc, e.cyc);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_op", rsp_op, e.op);
        chk("rsp_err", rsp_err, e.err);
        d0 = rsp_data;
        o0 = rsp_op;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, d0);
            chk("bp_op", rsp_op, o0);
            chk("bp_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("turn_req_ready", req_ready, 1);
        chk("turn_rsp_valid", rsp_valid, 0);
    endtask

    task automatic txn(input logic [3:0] op, input logic [3:0] a, b, c, d, input logic [3:0] exp_data);
        send(op, a, b, c, d, exp_data);
        recv(0);
    endtask

    initial begin
        int seen;
        logic [3:0] op, a, b, c, d;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_op", rsp_op, 0);
        chk("rst_rsp_err", rsp_err, 0);
        rst = 1'b0;
        @(negedge clk);

        txn(4'd0, 4'd0, 4'd9, 4'd8, 4'd0, 4'b0001);
        txn(4'd1, 4'd0, 4'b1011, 4'd2, 4'd0, 4'b0010);
        txn(4'd1, 4'd0, 4'b1011, 4'd15, 4'd0, 4'b0000);
        txn(4'd1, 4'd0, 4'b1011, 4'd0, 4'd0, 4'b1011);
        txn(4'd7, 4'd0, 4'd0, 4'b0101, 4'b1011, 4'b0110);
        txn(4'd8, 4'd3, 4'd7, 4'd0, 4'd0, 4'd7);
        txn(4'd6, 4'd5, 4'd6, 4'd0, 4'd2, 4'b0001);
        txn(4'd12, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0);
        txn(4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        txn(4'd3, 4'd9, 4'd0, 4'd0, 4'd9, 4'd1);

        send(4'd4, 4'd0, 4'b1110, 4'b0111, 4'd0, 4'b0110);
        recv(5);

        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 15));
            a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
            txn(op, a, b, c, d, model(op, a, b, c, d));
        end

        send(4'd1, 4'd0, 4'b1111, 4'd3, 4'd0, 4'b0001);
`ifdef OP_EXEC_SERIAL_SHIFT_EN
        @(negedge clk);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("abort_req_ready", req_ready, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_data", rsp_data, 0);
        chk("abort_rsp_op", rsp_op, 0);
        chk("abort_rsp_err", rsp_err, 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("abort_no_rsp", seen, 0);

        txn(4'd0, 4'd0, 4'd15, 4'd3, 4'd0, 4'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
